cnt_wrap_tracker: RTL and testbench
===================================

// Module: cnt_wrap_tracker
// PURPOSE
//   Downstream monitor for reversible_counter_sar. Samples the counter's cnt
//   and up_down every clock. Detects wrap-around in both directions and
//   extends the narrow count into a wider signed-free running count with
//   wrap pulses. Feeds status/debug logic that needs a count range wider
//   than 2^CNT_W.
// PARAMETERS
//   CNT_W  4  width of monitored cnt; must be >= 2 so a wrap is never also a +/-1 step
//   EXT_W  4  width of wrap accumulator (upper bits of ext_cnt)
// PORTS
//   clk       in   1              single clock; all state on rising edge
//   rst_n     in   1              asynchronous, active-low reset
//   up_down   in   1              counter direction, 1 = up, 0 = down
//   cnt       in   CNT_W          counter value to monitor
//   ext_cnt   out  EXT_W+CNT_W    extended count {wrap_acc, cnt_sample}
//   wrap_up   out  1              1-cycle pulse: MAX->0 transition seen
//   wrap_dn   out  1              1-cycle pulse: 0->MAX transition seen
//   dir_chg   out  1              1-cycle pulse: up_down differs from previous sample
//   ext_ovf   out  1              sticky: wrap_acc wrapped in either direction
//   jump_err  out  1              sticky: illegal cnt step (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async assert, sync release by clk): all outputs 0, wrap_acc=0,
//     prev_cnt=0, prev_dir=0, FSM=INIT. Reset mid-operation aborts at once.
//   - FSM: INIT -> TRACK on first clock after reset release; TRACK holds
//     until reset. No other transitions.
//   - INIT cycle: prev_cnt<=cnt, prev_dir<=up_down, ext_cnt<={0,cnt};
//     no pulses, no error checks (baseline only).
//   - TRACK, each clock, with MAX = 2^CNT_W-1:
//     prev_cnt==MAX && cnt==0 -> wrap_acc+1, wrap_up=1
//     prev_cnt==0 && cnt==MAX -> wrap_acc-1, wrap_dn=1
//     otherwise wrap_acc unchanged. Decision uses values only, not up_down.
//   - wrap_acc arithmetic modulo 2^EXT_W; increment from 2^EXT_W-1 -> 0, or
//     decrement from 0 -> 2^EXT_W-1, sets ext_ovf (sticky until reset).
//   - dir_chg=1 in TRACK when up_down != prev_dir; prev_dir<=up_down every clock.
//   - ext_cnt <= {wrap_acc_next, cnt}; latency 1 clock from cnt sample.
//   - Outputs are registered; pulses last exactly one clock; back-to-back
//     wraps (CNT_W small) give consecutive pulses, each counted.
//   - Same-clock wrap and dir_chg: both reported independently.
//   - cnt holding (prev_cnt==cnt): legal, no pulse, no change.
// CONFIGURATION
//   Macro CNT_JUMP_CHECK_EN:
//   - Defined: in TRACK, jump_err set (sticky) when cnt is not prev_cnt,
//     prev_cnt+1 or prev_cnt-1 (mod 2^CNT_W); wrap_acc update still applied
//     per rules above; err checked from the second sample after reset.
//   - Undefined: checker logic absent; jump_err tied to 0.
// TESTING
//   1. rst_n=0 4ps then 1, up_down=1, cnt 0..15..0 -> wrap_up once at 15->0,
//      ext_cnt=0x10 one clock after cnt=0 sampled, ext_ovf=0.
//   2. up_down=0, cnt 2,1,0,15,14 -> wrap_dn once, ext_cnt 0x02,0x01,0x00,0xFF,0xFE.
//   3. up_down toggled 1->0 at a cnt=7 -> dir_chg one-clock pulse, ext_cnt unchanged.
//   4. 16 up-wraps from ext_cnt=0xF0 region -> wrap_acc 15->0, ext_ovf=1 and
//      held through later traffic until rst_n low.
//   5. rst_n low mid-count (cnt=9, wrap_acc=3) -> all outputs 0 immediately;
//      after release first sample is baseline, no pulse.
//   6. CNT_JUMP_CHECK_EN defined: cnt 4 -> 7 -> jump_err=1 sticky; undefined:
//      same stimulus -> jump_err=0.

Source files
------------

// File: rtl/cnt_wrap_tracker.sv
// cnt_wrap_tracker: extends a narrow up/down count into {wrap_acc, cnt} with wrap/dir pulses; optional CNT_JUMP_CHECK_EN.
// Latency 1 clk from cnt sample; no backpressure, cnt/up_down sampled every clock.
`timescale 1ns/1ps
module cnt_wrap_tracker #(
  parameter int CNT_W = 4,
  parameter int EXT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   up_down,
  input  logic [CNT_W-1:0]       cnt,
  output logic [EXT_W+CNT_W-1:0] ext_cnt,
  output logic                   wrap_up,
  output logic                   wrap_dn,
  output logic                   dir_chg,
  output logic                   ext_ovf,
  output logic                   jump_err
);

  localparam logic [0:0]       ST_INIT  = 1'b0;
  localparam logic [0:0]       ST_TRACK = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [EXT_W-1:0] ACC_MAX  = '1;

  logic [0:0]       state;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_dir;
  logic [EXT_W-1:0] wrap_acc;
  logic [EXT_W-1:0] wrap_acc_next;
  logic             is_wrap_up;
  logic             is_wrap_dn;
  logic             acc_ovf;
  logic             is_dir_chg;

  // Wrap decision is purely value based; up_down only feeds dir_chg.
  always_comb begin
    is_wrap_up    = (state == ST_TRACK) && (prev_cnt == CNT_MAX) && (cnt == '0);
    is_wrap_dn    = (state == ST_TRACK) && (prev_cnt == '0) && (cnt == CNT_MAX);
    is_dir_chg    = (state == ST_TRACK) && (up_down != prev_dir);
    wrap_acc_next = wrap_acc;
    acc_ovf       = 1'b0;
    if (is_wrap_up) begin
      wrap_acc_next = wrap_acc + EXT_W'(1);
      acc_ovf       = (wrap_acc == ACC_MAX);
    end else if (is_wrap_dn) begin
      wrap_acc_next = wrap_acc - EXT_W'(1);
      acc_ovf       = (wrap_acc == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      prev_cnt <= '0;
      prev_dir <= 1'b0;
      wrap_acc <= '0;
      ext_cnt  <= '0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      dir_chg  <= 1'b0;
      ext_ovf  <= 1'b0;
    end else begin
      state    <= ST_TRACK;
      prev_cnt <= cnt;
      prev_dir <= up_down;
      wrap_acc <= wrap_acc_next;
      ext_cnt  <= {wrap_acc_next, cnt};
      wrap_up  <= is_wrap_up;
      wrap_dn  <= is_wrap_dn;
      dir_chg  <= is_dir_chg;
      if (acc_ovf) begin
        ext_ovf <= 1'b1;
      end
    end
  end

`ifdef CNT_JUMP_CHECK_EN
  // Legal steps are hold, +1 or -1 modulo 2^CNT_W; the INIT sample is only a baseline.
  logic jump_bad;
  assign jump_bad = (state == ST_TRACK) &&
                    (cnt != prev_cnt) &&
                    (cnt != prev_cnt + CNT_W'(1)) &&
                    (cnt != prev_cnt - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_err <= 1'b0;
    end else if (jump_bad) begin
      jump_err <= 1'b1;
    end
  end
`else
  assign jump_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_wrap_tracker.sv
// Bench for cnt_wrap_tracker: constant vector table, directed corner sequences, random traffic vs. an unbounded-count model.
`timescale 1ns/1ps
module tb_cnt_wrap_tracker;

  localparam int CNT_W = 4;
  localparam int EXT_W = 4;
  localparam int MODC  = 1 << CNT_W;
`ifdef CNT_JUMP_CHECK_EN
  localparam bit JCHK = 1'b1;
`else
  localparam bit JCHK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   up_down = 1'b1;
  logic [CNT_W-1:0]       cnt = '0;
  logic [EXT_W+CNT_W-1:0] ext_cnt;
  logic                   wrap_up, wrap_dn, dir_chg, ext_ovf, jump_err;

  cnt_wrap_tracker #(.CNT_W(CNT_W), .EXT_W(EXT_W)) dut (
    .clk(clk), .rst_n(rst_n), .up_down(up_down), .cnt(cnt),
    .ext_cnt(ext_cnt), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .dir_chg(dir_chg), .ext_ovf(ext_ovf), .jump_err(jump_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: wrap count as an unbounded integer; the DUT accumulator is its low EXT_W bits.
  bit        m_init;
  int        m_acc;
  logic [3:0] m_prev;
  bit        m_pdir;
  bit        m_ovf, m_jerr;
  logic [7:0] e_ext;
  bit        e_wu, e_wd, e_dc;

  task automatic model_reset();
    m_init = 1; m_acc = 0; m_prev = '0; m_pdir = 0;
    m_ovf = 0; m_jerr = 0; e_ext = '0; e_wu = 0; e_wd = 0; e_dc = 0;
  endtask

  task automatic model_step(input bit ud, input logic [3:0] c);
    int old_acc;
    int d;
    e_wu = 0; e_wd = 0; e_dc = 0;
    if (m_init) begin
      m_init = 0;
    end else begin
      old_acc = m_acc;
      if (m_prev == 4'(MODC - 1) && c == 4'd0) begin
        m_acc = m_acc + 1; e_wu = 1;
      end else if (m_prev == 4'd0 && c == 4'(MODC - 1)) begin
        m_acc = m_acc - 1; e_wd = 1;
      end
      if ((old_acc >>> EXT_W) != (m_acc >>> EXT_W)) m_ovf = 1;
      e_dc = (ud != m_pdir);
      d = (int'(c) - int'(m_prev) + MODC) % MODC;
      if (JCHK && !(d == 0 || d == 1 || d == MODC - 1)) m_jerr = 1;
    end
    m_prev = c;
    m_pdir = ud;
    e_ext  = {m_acc[EXT_W-1:0], c};
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ext_cnt"},  32'(ext_cnt),  32'(e_ext));
    chk({tag, ".wrap_up"},  32'(wrap_up),  32'(e_wu));
    chk({tag, ".wrap_dn"},  32'(wrap_dn),  32'(e_wd));
    chk({tag, ".dir_chg"},  32'(dir_chg),  32'(e_dc));
    chk({tag, ".ext_ovf"},  32'(ext_ovf),  32'(m_ovf));
    chk({tag, ".jump_err"}, 32'(jump_err), 32'(m_jerr));
  endtask

  // Asserts reset away from the clock edge, checks the immediate clear, releases before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_ext"},  32'(ext_cnt),  32'h0);
    chk({tag, ".rst_wu"},   32'(wrap_up),  32'h0);
    chk({tag, ".rst_wd"},   32'(wrap_dn),  32'h0);
    chk({tag, ".rst_dc"},   32'(dir_chg),  32'h0);
    chk({tag, ".rst_ovf"},  32'(ext_ovf),  32'h0);
    chk({tag, ".rst_jerr"}, 32'(jump_err), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic step(input bit ud, input logic [3:0] c);
    @(negedge clk);
    up_down = ud;
    cnt     = c;
    @(posedge clk);
    #1;
    model_step(ud, c);
  endtask

  typedef struct {
    bit         rst;
    bit         ud;
    logic [3:0] c;
    logic [7:0] ext;
    logic [3:0] f;   // {wrap_up, wrap_dn, dir_chg, ext_ovf}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input bit ud, input logic [3:0] c,
                             input logic [7:0] ext, input logic [3:0] f);
    vec_t r;
    r.rst = rst; r.ud = ud; r.c = c; r.ext = ext; r.f = f;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cur;
    bit         rud;
    int         r;

    #1;
    chk("por.ext_cnt", 32'(ext_cnt), 32'h0);
    chk("por.ext_ovf", 32'(ext_ovf), 32'h0);

    // Full up count with one wrap.
    tbl.push_back(v(1'b1, 1'b0, 4'd0, 8'h00, 4'b0000));
    tbl.push_back(v(1'b0, 1'b1, 4'd0, 8'h00, 4'b0000));
    for (int i = 1; i < 16; i++) tbl.push_back(v(1'b0, 1'b1, 4'(i), 8'(i), 4'b0000));
    tbl.push_back(v(1'b0, 1'b1, 4'd0, 8'h10, 4'b1000));
    tbl.push_back(v(1'b0, 1'b1, 4'd1, 8'h11, 4'b0000));
    // Down through zero: accumulator underflows, so ext_ovf sets too.
    tbl.push_back(v(1'b1, 1'b0, 4'd0, 8'h00, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 4'd2, 8'h02, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 4'd1, 8'h01, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 4'd0, 8'h00, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 4'd15, 8'hFF, 4'b0101));
    tbl.push_back(v(1'b0, 1'b0, 4'd14, 8'hFE, 4'b0001));
    // Direction change at cnt=7.
    tbl.push_back(v(1'b1, 1'b0, 4'd0, 8'h00, 4'b0000));
    tbl.push_back(v(1'b0, 1'b1, 4'd6, 8'h06, 4'b0000));
    tbl.push_back(v(1'b0, 1'b1, 4'd7, 8'h07, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 4'd7, 8'h07, 4'b0010));
    tbl.push_back(v(1'b0, 1'b0, 4'd6, 8'h06, 4'b0000));

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        do_reset($sformatf("tbl%0d", k));
      end else begin
        step(tbl[k].ud, tbl[k].c);
        chk($sformatf("tbl%0d.ext_cnt", k),  32'(ext_cnt),  32'(tbl[k].ext));
        chk($sformatf("tbl%0d.wrap_up", k),  32'(wrap_up),  32'(tbl[k].f[3]));
        chk($sformatf("tbl%0d.wrap_dn", k),  32'(wrap_dn),  32'(tbl[k].f[2]));
        chk($sformatf("tbl%0d.dir_chg", k),  32'(dir_chg),  32'(tbl[k].f[1]));
        chk($sformatf("tbl%0d.ext_ovf", k),  32'(ext_ovf),  32'(tbl[k].f[0]));
        chk($sformatf("tbl%0d.jump_err", k), 32'(jump_err), 32'h0);
      end
    end

    // Sixteen up-wraps: accumulator 15 -> 0 sets ext_ovf, which then stays.
    do_reset("ovf");
    step(1'b1, 4'd0);
    for (int w = 0; w < 16; w++) begin
      for (int i = 1; i < 16; i++) begin
        step(1'b1, 4'(i));
        check_model("ovf");
      end
      step(1'b1, 4'd0);
      check_model("ovf");
      if (w == 14) begin
        chk("ovf.ext_F0", 32'(ext_cnt), 32'h0F0);
        chk("ovf.pre",    32'(ext_ovf), 32'h0);
      end
    end
    chk("ovf.ext_00", 32'(ext_cnt), 32'h000);
    chk("ovf.set",    32'(ext_ovf), 32'h1);
    step(1'b0, 4'd15);
    step(1'b0, 4'd14);
    step(1'b0, 4'd13);
    check_model("ovf_hold");
    chk("ovf.held", 32'(ext_ovf), 32'h1);

    // Reset mid-count with wrap_acc=3, then baseline-only first sample.
    do_reset("mid");
    step(1'b1, 4'd0);
    for (int w = 0; w < 3; w++) begin
      for (int i = 1; i < 16; i++) step(1'b1, 4'(i));
      step(1'b1, 4'd0);
    end
    for (int i = 1; i < 10; i++) step(1'b1, 4'(i));
    chk("mid.ext_39", 32'(ext_cnt), 32'h39);
    do_reset("mid");
    step(1'b0, 4'd15);
    chk("mid.base_ext", 32'(ext_cnt), 32'h0F);
    chk("mid.base_wd",  32'(wrap_dn), 32'h0);
    chk("mid.base_dc",  32'(dir_chg), 32'h0);
    step(1'b0, 4'd14);
    check_model("mid_after");

    // Illegal jump 4 -> 7.
    do_reset("jump");
    step(1'b1, 4'd4);
    step(1'b1, 4'd7);
    chk("jump.err", 32'(jump_err), 32'(JCHK));
    check_model("jump");
    step(1'b1, 4'd8);
    chk("jump.sticky", 32'(jump_err), 32'(JCHK));

    // Random traffic, mostly legal steps in the current direction.
    do_reset("rnd");
    cur = 4'($urandom);
    rud = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset("rnd");
        continue;
      end
      if ($urandom_range(0, 7) == 0) rud = ~rud;
      r = int'($urandom_range(0, 15));
      if (r < 10)      cur = rud ? cur + 4'd1 : cur - 4'd1;
      else if (r < 12) cur = rud ? cur - 4'd1 : cur + 4'd1;
      else if (r == 15 && $urandom_range(0, 3) == 0) cur = 4'($urandom);
      step(rud, cur);
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
